// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/flush controller: load-use stalls, branch flushes, data-memory wait FSM
// with timeout recovery, and EX forwarding selects. Optional perf counters under PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 7
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic        ID_use1,
    input  logic        ID_use2,
    input  logic [4:0]  EX_rs1,
    input  logic [4:0]  EX_rs2,
    input  logic [4:0]  EX_rd,
    input  logic        EX_memread,
    input  logic        EX_br_taken,
    input  logic [4:0]  MEM_rd,
    input  logic        MEM_regwrite,
    input  logic [4:0]  WB_rd,
    input  logic        WB_regwrite,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_stall,
    output logic        IF_ID_stall,
    output logic        ID_EX_stall,
    output logic        EX_MEM_stall,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic        MEM_WB_flush,
    output logic [1:0]  fwdA,
    output logic [1:0]  fwdB,
    output logic        mem_err,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, MEMWAIT, RECOVER} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             load_use;

    assign load_use = EX_memread && (EX_rd != 5'd0) &&
                      ((ID_use1 && (EX_rd == ID_rs1)) || (ID_use2 && (EX_rd == ID_rs2)));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // All outputs are forced low while Rst is held, including the combinational ones.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        pc_stall     = 1'b0;
        IF_ID_stall  = 1'b0;
        ID_EX_stall  = 1'b0;
        EX_MEM_stall = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        MEM_WB_flush = 1'b0;
        mem_err      = 1'b0;
        fwdA         = 2'b00;
        fwdB         = 2'b00;
        if (!Rst) begin
            if (MEM_regwrite && (MEM_rd != 5'd0) && (MEM_rd == EX_rs1))     fwdA = 2'b10;
            else if (WB_regwrite && (WB_rd != 5'd0) && (WB_rd == EX_rs1))   fwdA = 2'b01;
            if (MEM_regwrite && (MEM_rd != 5'd0) && (MEM_rd == EX_rs2))     fwdB = 2'b10;
            else if (WB_regwrite && (WB_rd != 5'd0) && (WB_rd == EX_rs2))   fwdB = 2'b01;

            case (state_q)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        pc_stall     = 1'b1;
                        IF_ID_stall  = 1'b1;
                        ID_EX_stall  = 1'b1;
                        EX_MEM_stall = 1'b1;
                        MEM_WB_flush = 1'b1;
                        state_d      = MEMWAIT;
                        wait_cnt_d   = CNT_W'(1);
                    end else if (EX_br_taken) begin
                        IF_ID_flush  = 1'b1;
                        ID_EX_flush  = 1'b1;
                    end else if (load_use) begin
                        pc_stall     = 1'b1;
                        IF_ID_stall  = 1'b1;
                        ID_EX_flush  = 1'b1;
                    end
                end
                MEMWAIT: begin
                    // EX is frozen here, so branch and load-use are not looked at.
                    if (mem_ready) begin
                        state_d    = RUN;
                        wait_cnt_d = '0;
                    end else begin
                        pc_stall     = 1'b1;
                        IF_ID_stall  = 1'b1;
                        ID_EX_stall  = 1'b1;
                        EX_MEM_stall = 1'b1;
                        MEM_WB_flush = 1'b1;
                        if (wait_cnt_q == CNT_W'(MEM_TIMEOUT)) begin
                            mem_err    = 1'b1;
                            state_d    = RECOVER;
                            wait_cnt_d = '0;
                        end else begin
                            wait_cnt_d = wait_cnt_q + CNT_W'(1);
                        end
                    end
                end
                RECOVER: begin
                    pc_stall     = 1'b1;
                    IF_ID_flush  = 1'b1;
                    ID_EX_flush  = 1'b1;
                    MEM_WB_flush = 1'b1;
                    state_d      = RUN;
                end
                default: begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            endcase
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stall_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            if (pc_stall)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (IF_ID_flush || ID_EX_flush || MEM_WB_flush)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 32'h0;
    assign flush_cnt = 32'h0;
`endif

endmodule
